// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the memory access arbiter.
//   DataWidth_t : per-access width code carried through to the bank
//   ClientId_t  : client index, sized for the largest supported client count (8)
//   MemReq_t    : one client request {write, addr, data, width}
//   InFlight_t  : one in-flight read tracker entry {valid, client id}
package mem_access_arbiter_pkg;

   localparam int unsigned MAX_CLIENTS = 8;
   localparam int unsigned CLIENT_ID_W = $clog2(MAX_CLIENTS);
   localparam int unsigned MEM_ADDR_W  = 16;
   localparam int unsigned MEM_DATA_W  = 32;

   typedef enum logic [1:0] {
      DW_BYTE  = 2'd0,
      DW_HALF  = 2'd1,
      DW_WORD  = 2'd2,
      DW_DWORD = 2'd3
   } DataWidth_t;

   localparam int unsigned DW_BITS = $bits(DataWidth_t);

   typedef logic [CLIENT_ID_W-1:0] ClientId_t;

   typedef struct packed {
      logic                  write;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] data;
      DataWidth_t            width;
   } MemReq_t;

   typedef struct packed {
      logic      valid;
      ClientId_t id;
   } InFlight_t;

endpackage

// File: rtl/mem_access_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting at
// the pointer and grants the first requester found.
//   req         : per-client request
//   ptr         : current round-robin pointer (client searched first)
//   grant       : one-hot grant (all zero when nothing requested)
//   grant_valid : any grant this cycle
//   grant_id    : index of the granted client
//   next_ptr    : pointer value following this grant (ptr when no grant)
module rr_arbiter
   import mem_access_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CLIENTS = 4
) (
   input  logic [NUM_CLIENTS-1:0] req,
   input  ClientId_t              ptr,
   output logic [NUM_CLIENTS-1:0] grant,
   output logic                   grant_valid,
   output ClientId_t              grant_id,
   output ClientId_t              next_ptr
);

   logic [NUM_CLIENTS-1:0]   req_rot;
   logic [NUM_CLIENTS-1:0]   gnt_rot;
   logic [2*NUM_CLIENTS-1:0] gnt_dbl;
   logic                     found;

   // Rotate requests so bit 0 is the pointer's client, pick lowest set bit,
   // then rotate the one-hot grant back into client order.
   always_comb begin
      req_rot     = '0;
      gnt_rot     = '0;
      gnt_dbl     = '0;
      found       = 1'b0;
      grant       = '0;
      grant_valid = 1'b0;
      grant_id    = '0;
      next_ptr    = ptr;

      req_rot = NUM_CLIENTS'({req, req} >> ptr);

      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         if (!found && req_rot[i]) begin
            found      = 1'b1;
            gnt_rot[i] = 1'b1;
            grant_id   = ClientId_t'((32'(ptr) + i) % NUM_CLIENTS);
            next_ptr   = ClientId_t'((32'(ptr) + i + 1) % NUM_CLIENTS);
         end
      end

      gnt_dbl     = {{NUM_CLIENTS{1'b0}}, gnt_rot} << ptr;
      grant       = gnt_dbl[NUM_CLIENTS-1:0] | gnt_dbl[2*NUM_CLIENTS-1:NUM_CLIENTS];
      grant_valid = found;
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter in front of a single memory bank. Grants at most one
// client request per cycle, issues it to the bank one cycle later, and routes
// read data back to the requesting client READ_LATENCY cycles after issue.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_*             : per-client request channel (valid/ready handshake)
//   rsp_valid/data    : one-hot read response, data shared by all clients
//   mem_wr_*          : bank write access signals
//   mem_rd_*          : bank read access signals, mem_rd_data from the bank
// Optional: define MEM_ARB_STATS_EN to add stats_clr and per-client
// saturating 16-bit stall counters (stall_cnt).
module mem_access_arbiter
   import mem_access_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CLIENTS  = 4,
   parameter int unsigned ADDR_W       = MEM_ADDR_W,
   parameter int unsigned DATA_W       = MEM_DATA_W,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CLIENTS-1:0]        req_valid,
   input  logic [NUM_CLIENTS-1:0]        req_write,
   input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_CLIENTS*DATA_W-1:0] req_data,
   input  logic [NUM_CLIENTS*DW_BITS-1:0] req_width,
   output logic [NUM_CLIENTS-1:0]        req_ready,
   output logic [NUM_CLIENTS-1:0]        rsp_valid,
   output logic [DATA_W-1:0]             rsp_data,
   output logic                          mem_wr_en,
   output logic                          mem_wr_chip_en,
   output logic [ADDR_W-1:0]             mem_wr_addr,
   output logic [DATA_W-1:0]             mem_wr_data,
   output logic [DW_BITS-1:0]            mem_wr_width,
   output logic                          mem_rd_en,
   output logic [ADDR_W-1:0]             mem_rd_addr,
   output logic [DW_BITS-1:0]            mem_rd_width,
   input  logic [DATA_W-1:0]             mem_rd_data
`ifdef MEM_ARB_STATS_EN
   ,
   input  logic                          stats_clr,
   output logic [NUM_CLIENTS*16-1:0]     stall_cnt
`endif
);

   logic [NUM_CLIENTS-1:0] arb_req;
   logic [NUM_CLIENTS-1:0] grant;
   logic                   grant_valid;
   ClientId_t              grant_id;
   ClientId_t              rr_ptr_q;
   ClientId_t              rr_ptr_nxt;
   MemReq_t                sel_req;
   InFlight_t              pipe_q [READ_LATENCY];
   InFlight_t              pipe_tail;
   logic [NUM_CLIENTS-1:0] rsp_dec;

   // No grants while reset is asserted, so no request is consumed and lost.
   assign arb_req = rst_n ? req_valid : '0;

   rr_arbiter #(
      .NUM_CLIENTS (NUM_CLIENTS)
   ) u_rr_arbiter (
      .req         (arb_req),
      .ptr         (rr_ptr_q),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .next_ptr    (rr_ptr_nxt)
   );

   assign req_ready = grant;

   // Read data is a straight passthrough; only rsp_valid qualifies it.
   assign rsp_data = mem_rd_data;

   // Mux out the granted client's request fields.
   always_comb begin
      sel_req = '0;
      for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
         if (grant[k]) begin
            sel_req.write = req_write[k];
            sel_req.addr  = MEM_ADDR_W'(req_addr[k*ADDR_W +: ADDR_W]);
            sel_req.data  = MEM_DATA_W'(req_data[k*DATA_W +: DATA_W]);
            sel_req.width = DataWidth_t'(req_width[k*DW_BITS +: DW_BITS]);
         end
      end
   end

   // Issue registers: enables pulse for one cycle; addr/data/width hold when idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q       <= '0;
         mem_wr_en      <= 1'b0;
         mem_wr_chip_en <= 1'b0;
         mem_wr_addr    <= '0;
         mem_wr_data    <= '0;
         mem_wr_width   <= '0;
         mem_rd_en      <= 1'b0;
         mem_rd_addr    <= '0;
         mem_rd_width   <= '0;
      end else begin
         rr_ptr_q       <= rr_ptr_nxt;
         mem_wr_en      <= grant_valid & sel_req.write;
         mem_wr_chip_en <= grant_valid & sel_req.write;
         mem_rd_en      <= grant_valid & ~sel_req.write;
         if (grant_valid && sel_req.write) begin
            mem_wr_addr  <= ADDR_W'(sel_req.addr);
            mem_wr_data  <= DATA_W'(sel_req.data);
            mem_wr_width <= DW_BITS'(sel_req.width);
         end
         if (grant_valid && !sel_req.write) begin
            mem_rd_addr  <= ADDR_W'(sel_req.addr);
            mem_rd_width <= DW_BITS'(sel_req.width);
         end
      end
   end

   // Decode the oldest in-flight entry into a one-hot response valid.
   always_comb begin
      pipe_tail = pipe_q[READ_LATENCY-1];
      rsp_dec   = '0;
      for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
         rsp_dec[k] = pipe_tail.valid && (pipe_tail.id == ClientId_t'(k));
      end
   end

   // In-flight read tracker: stage 0 lines up with mem_rd_en, and the final
   // registered rsp_valid lines up with the bank's read data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
         rsp_valid <= '0;
      end else begin
         pipe_q[0].valid <= grant_valid & ~sel_req.write;
         pipe_q[0].id    <= grant_id;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
         rsp_valid <= rsp_dec;
      end
   end

`ifdef MEM_ARB_STATS_EN
   localparam int unsigned CNT_W = 16;

   // Per-client stall counters; clear has priority, saturate at all ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            if (stats_clr) begin
               stall_cnt[k*CNT_W +: CNT_W] <= '0;
            end else if (req_valid[k] && !grant[k] &&
                         (stall_cnt[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
               stall_cnt[k*CNT_W +: CNT_W] <= stall_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a small latency-2 bank model.
module tb_mem_access_arbiter;

   localparam int unsigned NC = 4;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned RL = 2;
   localparam int unsigned WB = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NC-1:0]     req_valid = '0;
   logic [NC-1:0]     req_write = '0;
   logic [NC*AW-1:0]  req_addr = '0;
   logic [NC*DW-1:0]  req_data = '0;
   logic [NC*WB-1:0]  req_width = '0;
   logic [NC-1:0]     req_ready;
   logic [NC-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              mem_wr_en, mem_wr_chip_en, mem_rd_en;
   logic [AW-1:0]     mem_wr_addr, mem_rd_addr;
   logic [DW-1:0]     mem_wr_data, mem_rd_data;
   logic [WB-1:0]     mem_wr_width, mem_rd_width;
`ifdef MEM_ARB_STATS_EN
   logic              stats_clr = 1'b0;
   logic [NC*16-1:0]  stall_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   mem_access_arbiter #(
      .NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_data(req_data), .req_width(req_width), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .mem_wr_en(mem_wr_en), .mem_wr_chip_en(mem_wr_chip_en),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_width(mem_wr_width),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_width(mem_rd_width),
`ifdef MEM_ARB_STATS_EN
      .stats_clr(stats_clr), .stall_cnt(stall_cnt),
`endif
      .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   // Bank model: unwritten locations return a fixed pattern of the address.
   function automatic logic [DW-1:0] bank_init(input logic [AW-1:0] a);
      if (a == 16'h0040)      return 32'hDEAD_BEEF;
      else if (a[15:8] == 8'h01) return {24'hA0_0000, a[7:0]};
      else                    return {16'h5A5A, a};
   endfunction

   logic [DW-1:0] bank    [256];
   logic          written [256];
   logic [DW-1:0] rd_pipe [RL];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) written[i] <= 1'b0;
      end else if (mem_wr_en) begin
         bank[mem_wr_addr[7:0]]    <= mem_wr_data;
         written[mem_wr_addr[7:0]] <= 1'b1;
      end
      rd_pipe[0] <= written[mem_rd_addr[7:0]] ? bank[mem_rd_addr[7:0]] : bank_init(mem_rd_addr);
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   assign mem_rd_data = rd_pipe[RL-1];

   task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [WB-1:0] w);
      req_write[k]          = wr;
      req_addr[k*AW +: AW]  = a;
      req_data[k*DW +: DW]  = d;
      req_width[k*WB +: WB] = w;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 4'hF;
      req_write = 4'b0101;
      req_addr  = {4{16'hFFFF}};
      req_data  = {4{32'hFFFF_FFFF}};
      req_width = 8'hFF;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset.req_ready got=%b exp=0000", req_ready); end
      @(negedge clk);
      n_vec++; if ({mem_wr_en, mem_wr_chip_en, mem_rd_en} !== 3'b000) begin n_err++; $display("FAIL reset.enables got=%b exp=000", {mem_wr_en, mem_wr_chip_en, mem_rd_en}); end
      n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset.rsp_valid got=%b exp=0000", rsp_valid); end
      n_vec++; if ({mem_wr_addr, mem_rd_addr, mem_wr_data} !== 64'h0) begin n_err++; $display("FAIL reset.addr_data got=%h exp=0", {mem_wr_addr, mem_rd_addr, mem_wr_data}); end
      n_vec++; if ({mem_wr_width, mem_rd_width} !== 4'h0) begin n_err++; $display("FAIL reset.widths got=%h exp=0", {mem_wr_width, mem_rd_width}); end
      req_valid = '0;
      req_write = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_read;
      do_reset();
      @(negedge clk);                                  // grant cycle
      set_req(2, 1'b0, 16'h0040, 32'h0, 2'b10);
      req_valid = 4'b0100;
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_read.grant got=%b exp=0100", req_ready); end
      @(negedge clk);                                  // issue cycle
      req_valid = '0;
      n_vec++; if ({mem_rd_en, mem_wr_en} !== 2'b10) begin n_err++; $display("FAIL single_read.issue_en got=%b exp=10", {mem_rd_en, mem_wr_en}); end
      n_vec++; if (mem_rd_addr !== 16'h0040) begin n_err++; $display("FAIL single_read.rd_addr got=%h exp=0040", mem_rd_addr); end
      n_vec++; if (mem_rd_width !== 2'b10) begin n_err++; $display("FAIL single_read.rd_width got=%b exp=10", mem_rd_width); end
      @(negedge clk);
      n_vec++; if ({mem_rd_en, rsp_valid} !== 5'b0_0000) begin n_err++; $display("FAIL single_read.gap got=%b exp=00000", {mem_rd_en, rsp_valid}); end
      @(negedge clk);                                  // grant + 3
      n_vec++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL single_read.rsp_valid got=%b exp=0100", rsp_valid); end
      n_vec++; if (rsp_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_read.rsp_data got=%h exp=deadbeef", rsp_data); end
      @(negedge clk);
      n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_read.rsp_done got=%b exp=0000", rsp_valid); end
   endtask

   task automatic test_all_clients;
      logic [NC-1:0] pend, exp_gnt, exp_rsp;
      do_reset();
      for (int k = 0; k < 4; k++) set_req(k, 1'b0, 16'h0100 + 16'(k), 32'h0, 2'b10);
      pend = 4'hF;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_rsp = (c >= 3 && c <= 6) ? 4'(1 << (c - 3)) : 4'b0000;
         n_vec++; if (rsp_valid !== exp_rsp) begin n_err++; $display("FAIL all_clients.rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
         if (c >= 3 && c <= 6) begin
            n_vec++; if (rsp_data !== 32'hA000_0000 + 32'(c - 3)) begin n_err++; $display("FAIL all_clients.rsp_data c=%0d got=%h exp=%h", c, rsp_data, 32'hA000_0000 + 32'(c - 3)); end
         end
         req_valid = pend;
         #1;
         exp_gnt = (c < 4) ? 4'(1 << c) : 4'b0000;
         n_vec++; if (req_ready !== exp_gnt) begin n_err++; $display("FAIL all_clients.grant c=%0d got=%b exp=%b", c, req_ready, exp_gnt); end
         pend = pend & ~exp_gnt;
      end
      req_valid = '0;
   endtask

   task automatic test_write_then_read;
      do_reset();
      set_req(1, 1'b1, 16'h0010, 32'h1234_5678, 2'b10);
      set_req(3, 1'b0, 16'h0010, 32'h0, 2'b01);
      @(negedge clk);                                  // c0
      req_valid = 4'b1010;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wr_rd.grant_wr got=%b exp=0010", req_ready); end
      @(negedge clk);                                  // c1
      n_vec++; if ({mem_wr_en, mem_wr_chip_en, mem_rd_en} !== 3'b110) begin n_err++; $display("FAIL wr_rd.wr_issue got=%b exp=110", {mem_wr_en, mem_wr_chip_en, mem_rd_en}); end
      n_vec++; if ({mem_wr_addr, mem_wr_data, mem_wr_width} !== {16'h0010, 32'h1234_5678, 2'b10}) begin n_err++; $display("FAIL wr_rd.wr_fields got=%h/%h/%b exp=0010/12345678/10", mem_wr_addr, mem_wr_data, mem_wr_width); end
      req_valid = 4'b1000;
      #1;
      n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wr_rd.grant_rd got=%b exp=1000", req_ready); end
      @(negedge clk);                                  // c2
      req_valid = '0;
      n_vec++; if ({mem_wr_en, mem_rd_en} !== 2'b01) begin n_err++; $display("FAIL wr_rd.rd_issue got=%b exp=01", {mem_wr_en, mem_rd_en}); end
      n_vec++; if ({mem_rd_addr, mem_rd_width} !== {16'h0010, 2'b01}) begin n_err++; $display("FAIL wr_rd.rd_fields got=%h/%b exp=0010/01", mem_rd_addr, mem_rd_width); end
      @(negedge clk);                                  // c3
      n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL wr_rd.no_wr_rsp got=%b exp=0000", rsp_valid); end
      @(negedge clk);                                  // c4
      n_vec++; if (rsp_valid !== 4'b1000) begin n_err++; $display("FAIL wr_rd.rsp_valid got=%b exp=1000", rsp_valid); end
      n_vec++; if (rsp_data !== 32'h1234_5678) begin n_err++; $display("FAIL wr_rd.rsp_data got=%h exp=12345678", rsp_data); end
   endtask

   task automatic test_no_starvation;
      logic [NC-1:0] vld [4];
      logic [NC-1:0] gnt [4];
      vld = '{4'b0011, 4'b0011, 4'b0001, 4'b0001};
      gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0001};
      do_reset();
      set_req(0, 1'b0, 16'h0000, 32'h0, 2'b00);
      set_req(1, 1'b0, 16'h0001, 32'h0, 2'b00);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req_valid = vld[c];
         #1;
         n_vec++; if (req_ready !== gnt[c]) begin n_err++; $display("FAIL starve.grant c=%0d got=%b exp=%b", c, req_ready, gnt[c]); end
      end
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic test_reset_in_flight;
      do_reset();
      for (int k = 0; k < 4; k++) set_req(k, 1'b0, 16'h0100 + 16'(k), 32'h0, 2'b10);
      @(negedge clk);                                  // c0
      req_valid = 4'b0011;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_flight.grant0 got=%b exp=0001", req_ready); end
      @(negedge clk);                                  // c1
      req_valid = 4'b0010;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rst_flight.grant1 got=%b exp=0010", req_ready); end
      @(negedge clk);                                  // c2: reset asserted
      rst_n = 1'b0;
      req_valid = 4'hF;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_flight.ready_in_rst got=%b exp=0000", req_ready); end
      @(negedge clk);                                  // c3
      rst_n = 1'b1;
      req_valid = '0;
      n_vec++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_flight.rd_en got=%b exp=0", mem_rd_en); end
      for (int c = 3; c < 6; c++) begin
         if (c > 3) @(negedge clk);
         n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rst_flight.rsp c=%0d got=%b exp=0000", c, rsp_valid); end
      end
      @(negedge clk);                                  // c6
      req_valid = 4'hF;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_flight.ptr_reset got=%b exp=0001", req_ready); end
      @(negedge clk);
      req_valid = '0;
   endtask

`ifdef MEM_ARB_STATS_EN
   task automatic test_stats;
      logic vld3 [8];
      vld3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      stats_clr = 1'b0;
      for (int k = 0; k < 4; k++) set_req(k, 1'b0, 16'h0100 + 16'(k), 32'h0, 2'b10);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 7) begin
            n_vec++; if (stall_cnt[63:48] !== 16'd5) begin n_err++; $display("FAIL stats.cnt3 got=%0d exp=5", stall_cnt[63:48]); end
         end
         req_valid = {vld3[c], 3'b111};
         #1;
         if (c == 3 || c == 7) begin
            n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL stats.grant3 c=%0d got=%b exp=1000", c, req_ready); end
         end
      end
      @(negedge clk);
      req_valid = '0;
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      n_vec++; if (stall_cnt !== 64'h0) begin n_err++; $display("FAIL stats.clear got=%h exp=0", stall_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_all_clients();
      test_write_then_read();
      test_no_starvation();
      test_reset_in_flight();
`ifdef MEM_ARB_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
